config_lfsr: RTL and testbench
==============================

CONFIG_LFSR -- requirements
Module: config_lfsr

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning register width; legal range 4..32.
REQ-002 SHALL have parameter MODE, default 0, meaning 0 = many-to-one (Fibonacci), 1 = one-to-many (Galois).
REQ-003 SHALL have parameter TAPS, WIDTH bits, default 16'hB400, meaning tap mask (bit i set = state bit i participates).
REQ-004 SHALL have parameter SEED, WIDTH bits, default 16'h0001, meaning reset/recovery value; SEED == 0 SHALL fail elaboration.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port en, input, 1, meaning advance the LFSR one step this cycle.
REQ-008 SHALL have port load, input, 1, meaning load seed_in this cycle.
REQ-009 SHALL have port seed_in, input, WIDTH, meaning value to load.
REQ-010 SHALL have port data, output, WIDTH, meaning current LFSR state, registered.
REQ-011 SHALL have port step_cnt, output, WIDTH, meaning steps since last reset/load/wrap, registered.
REQ-012 SHALL have port wrap, output, 1, meaning one-cycle pulse when state returns to start value.
REQ-013 SHALL have port zero_fix, output, 1, meaning one-cycle pulse when an all-zero load was replaced by SEED.

Function
REQ-014 MODE 0 step SHALL be: fb = XOR-reduce(data & TAPS); next = {data[WIDTH-2:0], fb}.
REQ-015 MODE 1 step SHALL be: next = (data >> 1) XOR (data[0] ? TAPS : 0).
REQ-016 Priority SHALL be reset > load > en > hold; load with en high SHALL ignore en.
REQ-017 On load with seed_in != 0: data <= seed_in, start <= seed_in, step_cnt <= 0, wrap <= 0, zero_fix <= 0.
REQ-018 On load with seed_in == 0: data <= SEED, start <= SEED, step_cnt <= 0, zero_fix <= 1 for exactly one cycle.
REQ-019 data SHALL never hold all-zero after reset release; no other path to zero is permitted.
REQ-020 Internal register start SHALL hold the value last written by reset or load; it is not an output.
REQ-021 On en (no load): data <= next; if next == start then wrap <= 1 and step_cnt <= 0, else wrap <= 0 and step_cnt <= step_cnt + 1.
REQ-022 step_cnt SHALL wrap modulo 2^WIDTH silently (non-maximal TAPS); wrap SHALL depend only on start match.
REQ-023 When idle (no en, no load): data, step_cnt, start hold; wrap and zero_fix SHALL be 0.
REQ-024 Latency: data/wrap/step_cnt SHALL reflect an en or load on the following rising edge (one cycle); no combinational input-to-output path.
REQ-025 For maximal TAPS, wrap SHALL first assert exactly 2^WIDTH - 1 en-steps after reset/load.

Reset
REQ-026 While rst_n == 0 (asserted asynchronously, including mid-sequence): data = SEED, start = SEED, step_cnt = 0, wrap = 0, zero_fix = 0.
REQ-027 First step after rst_n release SHALL start from SEED; in-flight load/en during reset SHALL be discarded.

Verification
REQ-028 MODE 0, defaults, reset then 11 cycles en=1 -> data 0x0002 after step 1, 0x0400 after step 10, 0x0801 after step 11; step_cnt = 11.
REQ-029 MODE 1, defaults, reset then 2 cycles en=1 -> data 0xB400 then 0x5A00; step_cnt = 2.
REQ-030 MODE 0, defaults, en held 65535 cycles -> wrap pulses once at step 65535 with data = 0x0001, step_cnt = 0; no earlier wrap.
REQ-031 load=1, seed_in=0x0000 -> next cycle data = 0x0001, zero_fix = 1 for one cycle, step_cnt = 0.
REQ-032 load=1, en=1, seed_in=0x1234 -> data = 0x1234 (en ignored), step_cnt = 0; subsequent wrap targets 0x1234.
REQ-033 rst_n pulsed low mid-cycle after 5 steps -> data = 0x0001, step_cnt = 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/config_lfsr.sv
// Configurable LFSR: Fibonacci (MODE 0) or Galois (MODE 1) update, with load,
// all-zero substitution, and a step counter that restarts when the state returns to its start value.
module config_lfsr #(
  parameter int unsigned          WIDTH = 16,
  parameter int unsigned          MODE  = 0,
  parameter logic [WIDTH-1:0]     TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0]     SEED  = 16'h0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] step_cnt,
  output logic             wrap,
  output logic             zero_fix
);

  generate
    if (SEED == '0) begin : g_bad_seed
      $error("config_lfsr: SEED must be non-zero");
    end
    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
      $error("config_lfsr: WIDTH must be within 4..32");
    end
    if (MODE > 1) begin : g_bad_mode
      $error("config_lfsr: MODE must be 0 or 1");
    end
  endgenerate

  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] step_raw;
  logic [WIDTH-1:0] step_next;

  // A degenerate tap mask could shift the state into all-zero; substitute SEED
  // so the lock-up state is never reachable.
  always_comb begin
    step_raw = '0;
    if (MODE == 0) begin
      step_raw = {data[WIDTH-2:0], ^(data & TAPS)};
    end else begin
      step_raw = (data >> 1) ^ (data[0] ? TAPS : '0);
    end
    step_next = (step_raw == '0) ? SEED : step_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data     <= SEED;
      start    <= SEED;
      step_cnt <= '0;
      wrap     <= 1'b0;
      zero_fix <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      zero_fix <= 1'b0;
      if (load) begin
        step_cnt <= '0;
        if (seed_in == '0) begin
          data     <= SEED;
          start    <= SEED;
          zero_fix <= 1'b1;
        end else begin
          data  <= seed_in;
          start <= seed_in;
        end
      end else if (en) begin
        data <= step_next;
        if (step_next == start) begin
          wrap     <= 1'b1;
          step_cnt <= '0;
        end else begin
          step_cnt <= step_cnt + WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_config_lfsr.sv
// Scoreboard bench for config_lfsr: Fibonacci and Galois instances share stimulus;
// expected values are queued per cycle and checked by independent monitors.
module tb_config_lfsr;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] seed_in;
  logic [15:0] d0, c0, d1, c1;
  logic        w0, z0, w1, z1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  m;   // compare mask: 3=data 2=step_cnt 1=wrap 0=zero_fix
    logic [15:0] d;
    logic [15:0] c;
    logic        w;
    logic        z;
    string       nm;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  config_lfsr #(.WIDTH(16), .MODE(0), .TAPS(16'hB400), .SEED(16'h0001)) dut_fib (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed_in(seed_in),
    .data(d0), .step_cnt(c0), .wrap(w0), .zero_fix(z0)
  );

  config_lfsr #(.WIDTH(16), .MODE(1), .TAPS(16'hB400), .SEED(16'h0001)) dut_gal (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed_in(seed_in),
    .data(d1), .step_cnt(c1), .wrap(w1), .zero_fix(z1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] m, input logic [15:0] d, input logic [15:0] c,
                              input logic w, input logic z, input string nm);
    exp_t e;
    e.m = m; e.d = d; e.c = c; e.w = w; e.z = z; e.nm = nm;
    return e;
  endfunction

  task automatic score(input string who, input exp_t e, input logic [15:0] d,
                       input logic [15:0] c, input logic w, input logic z);
    logic ok;
    ok = 1'b1;
    if (e.m[3] && d !== e.d) ok = 1'b0;
    if (e.m[2] && c !== e.c) ok = 1'b0;
    if (e.m[1] && w !== e.w) ok = 1'b0;
    if (e.m[0] && z !== e.z) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s/%s: got data=%h cnt=%0d wrap=%b zf=%b want data=%h cnt=%0d wrap=%b zf=%b mask=%b",
               who, e.nm, d, c, w, z, e.d, e.c, e.w, e.z, e.m);
    end
  endtask

  task automatic direct(input string nm, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Monitors: each queued entry describes the outputs right after the next rising edge.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #2;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      if (e.m != 4'h0) score("fib", e, d0, c0, w0, z0);
    end
  end

  initial forever begin
    exp_t e;
    @(posedge clk);
    #2;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      if (e.m != 4'h0) score("gal", e, d1, c1, w1, z1);
    end
  end

  task automatic cyc(input logic e_in, input logic l_in, input logic [15:0] s_in,
                     input exp_t x0, input exp_t x1);
    @(negedge clk);
    en      = e_in;
    load    = l_in;
    seed_in = s_in;
    q0.push_back(x0);
    q1.push_back(x1);
  endtask

  logic [15:0] gal_seq [1:11];

  initial begin
    gal_seq[1]  = 16'hB400; gal_seq[2]  = 16'h5A00; gal_seq[3]  = 16'h2D00;
    gal_seq[4]  = 16'h1680; gal_seq[5]  = 16'h0B40; gal_seq[6]  = 16'h05A0;
    gal_seq[7]  = 16'h02D0; gal_seq[8]  = 16'h0168; gal_seq[9]  = 16'h00B4;
    gal_seq[10] = 16'h005A; gal_seq[11] = 16'h002D;

    en = 1'b0; load = 1'b0; seed_in = 16'h0000; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    direct("reset_data_fib", d0, 16'h0001);
    direct("reset_data_gal", d1, 16'h0001);
    direct("reset_cnt_fib", c0, 16'h0000);
    direct("reset_flags", {12'h0, w0, z0, w1, z1}, 16'h0000);

    en = 1'b1; load = 1'b1; seed_in = 16'h1234;
    @(posedge clk);
    #2;
    direct("reset_discard_fib", d0, 16'h0001);
    direct("reset_discard_gal", d1, 16'h0001);
    @(negedge clk);
    en = 1'b0; load = 1'b0; seed_in = 16'h0000;
    rst_n = 1'b1;

    for (int k = 1; k <= 5; k++)
      cyc(1'b1, 1'b0, 16'h0, mk(4'hF, 16'h0001 << k, 16'(k), 1'b0, 1'b0, "pre_rst"),
                             mk(4'hF, gal_seq[k], 16'(k), 1'b0, 1'b0, "pre_rst"));

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    direct("async_rst_data_fib", d0, 16'h0001);
    direct("async_rst_cnt_fib", c0, 16'h0000);
    direct("async_rst_data_gal", d1, 16'h0001);
    direct("async_rst_cnt_gal", c1, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 1; k <= 11; k++)
      cyc(1'b1, 1'b0, 16'h0,
          mk(4'hF, (k == 11) ? 16'h0801 : (16'h0001 << k), 16'(k), 1'b0, 1'b0, "run11"),
          mk(4'hF, gal_seq[k], 16'(k), 1'b0, 1'b0, "run11"));

    cyc(1'b0, 1'b0, 16'h0, mk(4'hF, 16'h0801, 16'd11, 1'b0, 1'b0, "idle"),
                           mk(4'hF, 16'h002D, 16'd11, 1'b0, 1'b0, "idle"));

    cyc(1'b0, 1'b1, 16'h0000, mk(4'hF, 16'h0001, 16'd0, 1'b0, 1'b1, "load_zero"),
                              mk(4'hF, 16'h0001, 16'd0, 1'b0, 1'b1, "load_zero"));
    cyc(1'b0, 1'b0, 16'h0000, mk(4'hF, 16'h0001, 16'd0, 1'b0, 1'b0, "zf_drop"),
                              mk(4'hF, 16'h0001, 16'd0, 1'b0, 1'b0, "zf_drop"));

    cyc(1'b1, 1'b1, 16'h1234, mk(4'hF, 16'h1234, 16'd0, 1'b0, 1'b0, "load_en"),
                              mk(4'hF, 16'h1234, 16'd0, 1'b0, 1'b0, "load_en"));
    cyc(1'b1, 1'b0, 16'h0000, mk(4'hF, 16'h2469, 16'd1, 1'b0, 1'b0, "step_from_load"),
                              mk(4'hF, 16'h091A, 16'd1, 1'b0, 1'b0, "step_from_load"));

    for (int k = 2; k <= 65535; k++)
      cyc(1'b1, 1'b0, 16'h0,
          mk((k == 65535) ? 4'hF : 4'h7, 16'h1234, (k == 65535) ? 16'd0 : 16'(k),
             (k == 65535), 1'b0, "long"),
          mk(4'h0, 16'h0, 16'h0, 1'b0, 1'b0, "long"));

    cyc(1'b1, 1'b0, 16'h0, mk(4'hF, 16'h2469, 16'd1, 1'b0, 1'b0, "after_wrap"),
                           mk(4'h0, 16'h0, 16'h0, 1'b0, 1'b0, "after_wrap"));
    cyc(1'b0, 1'b0, 16'h0, mk(4'hF, 16'h2469, 16'd1, 1'b0, 1'b0, "final_idle"),
                           mk(4'h0, 16'h0, 16'h0, 1'b0, 1'b0, "final_idle"));

    for (int i = 0; i < 20 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
    #3;
    total++;
    if (q0.size() > 0 || q1.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d entries left want 0/0", q0.size(), q1.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
